// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI slave running entirely on the system clock. The SPI pins are
//   oversampled through SYNC_STAGES flip-flops. Whole bytes are exchanged
//   with local logic through a one-byte TX holding register and an RX
//   output register with a one-cycle valid pulse.
//
// Ports
//   clk_i, rstn_i        system clock, asynchronous active-low reset
//   cpol_i, cpha_i       SPI mode; latched when select is first seen in IDLE
//   ssn_i, sck_i, mosi_i SPI pins from the master (asynchronous)
//   miso_o, miso_oe_o    serial data to the master and its output enable
//   tx_data_i/valid_i    byte into the TX holding register
//   tx_ready_o           TX holding register empty
//   rx_data_o/valid_o    last received byte and its one-cycle update pulse
//   tx_underrun_o        one-cycle pulse when a load finds the holding register empty
//   busy_o               high in LOAD and SHIFT
module spi_slave_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       ssn_i,
    input  logic       sck_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_e;

    state_e state_q;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ssn_sync_q;
    logic                   sck_prev_q;

    logic       cpol_q;
    logic       cpha_q;
    logic [7:0] shift_q;
    logic [7:0] hold_q;
    logic       hold_empty_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic [2:0] bit_cnt_q;
    logic       rx_valid_q;
    logic       underrun_q;
    logic       miso_oe_q;
    logic       busy_q;

    logic       sck_s;
    logic       mosi_s;
    logic       ssn_s;
    logic       sck_edge;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_evt;
    logic       shift_evt;
    logic       active;
    logic       load_evt;
    logic       tx_fire;
    logic [7:0] rx_byte_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ssn_s  = ssn_sync_q[SYNC_STAGES-1];

    // Pin synchronizers; select resets to the inactive level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ssn_sync_q  <= '1;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn_i};
            sck_prev_q  <= sck_s;
        end
    end

    always_comb begin
        sck_edge   = sck_s ^ sck_prev_q;
        // Leading edge leaves the CPOL idle level, trailing edge returns to it.
        lead_edge  = sck_edge & (sck_s ^ cpol_q);
        trail_edge = sck_edge & ~(sck_s ^ cpol_q);
        sample_evt = cpha_q ? trail_edge : lead_edge;
        shift_evt  = cpha_q ? lead_edge : trail_edge;
        active     = (state_q == ST_SHIFT) && !ssn_s;
        // A shift-edge with bit_cnt==0 marks a byte boundary: with CPHA=0 it is
        // the trailing edge after the 8th sample, with CPHA=1 the first leading edge.
        load_evt   = ((state_q == ST_LOAD) && !cpha_q) ||
                     (active && shift_evt && (bit_cnt_q == 3'd0));
        tx_fire    = tx_valid_i && hold_empty_q;
        rx_byte_d  = {rx_shift_q[6:0], mosi_s};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // A write in the same cycle as a load lands in the holding register;
            // the load itself still sees the old (empty) state.
            if (tx_fire) begin
                hold_q       <= tx_data_i;
                hold_empty_q <= 1'b0;
            end else if (load_evt) begin
                hold_empty_q <= 1'b1;
            end

            if (load_evt) begin
                shift_q    <= hold_empty_q ? 8'hFF : hold_q;
                underrun_q <= hold_empty_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!ssn_s) begin
                        state_q   <= ST_LOAD;
                        cpol_q    <= cpol_i;
                        cpha_q    <= cpha_i;
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (ssn_s) begin
                        // Deselect discards any partial byte.
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        if (sample_evt) begin
                            rx_shift_q <= rx_byte_d;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_byte_d;
                                rx_valid_q <= 1'b1;
                            end
                        end
                        if (shift_evt && (bit_cnt_q != 3'd0)) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso_o        = miso_oe_q & shift_q[7];
    assign miso_oe_o     = miso_oe_q;
    assign tx_ready_o    = hold_empty_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;
    assign busy_o        = busy_q;

endmodule
